array_feed_ctrl_a: RTL and testbench

- Read-side sequencer for the 64x16 A-operand memory: 1 write port, 4 read ports, with 4 rows of 16 words each.
- On `start`, it drives the 4 read-address ports with the diagonal (skewed) schedule the 4x4 systolic array needs. Lane i lags lane i-1 by one cycle.
- It raises per-lane valids aligned with the memory's registered read data, and signals completion.
- It also gates host writes into the memory so that A cannot change while a feed is running.

---
 rtl/array_feed_ctrl_a.sv | 97 +++++++++
 tb/tb_array_feed_ctrl_a.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_feed_ctrl_a.sv
// Skewed read-address sequencer for the A-operand memory feeding a 4x4 systolic array.
// done follows the accepting edge by K+4 edges; host writes are dropped (and flagged) while busy.
module array_feed_ctrl_a #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int ROW_STRIDE = 16,
  parameter int MAX_K      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        k_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr_0,
  output logic [ADDR_W-1:0] read_addr_1,
  output logic [ADDR_W-1:0] read_addr_2,
  output logic [ADDR_W-1:0] read_addr_3,
  output logic [3:0]        lane_valid,
  input  logic              host_w_en,
  input  logic [ADDR_W-1:0] host_w_addr,
  input  logic [DATA_W-1:0] host_w_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              wr_reject
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [4:0]        t, t_nxt;
  logic [4:0]        k_q, k_nxt;
  logic [3:0]        issue;
  logic [ADDR_W-1:0] addr [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      t          <= '0;
      k_q        <= '0;
      lane_valid <= '0;
      wr_reject  <= 1'b0;
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      k_q        <= k_nxt;
      lane_valid <= issue;
      wr_reject  <= host_w_en & busy;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    k_nxt     = k_q;
    case (state)
      IDLE: begin
        if (start && (k_len != 5'd0)) begin
          k_nxt     = (k_len > 5'(MAX_K)) ? 5'(MAX_K) : k_len;
          t_nxt     = '0;
          state_nxt = FEED;
        end
      end
      FEED: begin
        t_nxt = t + 5'd1;
        if (t == k_q + 5'd2) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane i walks row i, starting i cycles after lane 0.
  always_comb begin
    issue = '0;
    for (int i = 0; i < 4; i++) begin
      issue[i] = (state == FEED) && ({1'b0, t} >= 6'(i)) &&
                 ({1'b0, t} < (6'(i) + {1'b0, k_q}));
      addr[i]  = issue[i] ? (ADDR_W'(i * ROW_STRIDE) + ADDR_W'({1'b0, t} - 6'(i))) : '0;
    end
  end

  assign read_addr_0 = addr[0];
  assign read_addr_1 = addr[1];
  assign read_addr_2 = addr[2];
  assign read_addr_3 = addr[3];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign mem_w_en   = host_w_en & ~busy;
  assign mem_w_addr = host_w_addr;
  assign mem_w_data = host_w_data;

endmodule

// File: tb/tb_array_feed_ctrl_a.sv
// Directed bench for array_feed_ctrl_a with a 1-cycle-latency memory model behind it.
module tb_array_feed_ctrl_a;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [4:0]    k_len;
  logic          busy, done;
  logic [AW-1:0] read_addr_0, read_addr_1, read_addr_2, read_addr_3;
  logic [3:0]    lane_valid;
  logic          host_w_en;
  logic [AW-1:0] host_w_addr;
  logic [DW-1:0] host_w_data;
  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic          wr_reject;

  int n_chk  = 0;
  int n_pass = 0;
  int lv0_cnt;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] exp_mem [64];
  logic [DW-1:0] rd      [4];

  array_feed_ctrl_a dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .read_addr_0(read_addr_0), .read_addr_1(read_addr_1),
    .read_addr_2(read_addr_2), .read_addr_3(read_addr_3),
    .lane_valid(lane_valid),
    .host_w_en(host_w_en), .host_w_addr(host_w_addr), .host_w_data(host_w_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .wr_reject(wr_reject)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    rd[0] <= mem[read_addr_0];
    rd[1] <= mem[read_addr_1];
    rd[2] <= mem[read_addr_2];
    rd[3] <= mem[read_addr_3];
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; k_len = 5'd4;
    host_w_en = 1'b0; host_w_addr = '0; host_w_data = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) begin rst = 1'b0; start = 1'b0; end
      #1;
      n_chk++;
      if ({busy, done, lane_valid, wr_reject} !== 7'b0 ||
          {read_addr_0, read_addr_1, read_addr_2, read_addr_3} !== 24'b0)
        $display("FAIL reset_idle c=%0d busy=%b done=%b lv=%b rej=%b addr=%0d/%0d/%0d/%0d required all 0",
                 c, busy, done, lane_valid, wr_reject, read_addr_0, read_addr_1, read_addr_2, read_addr_3);
      else n_pass++;
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      host_w_en = 1'b1; host_w_addr = AW'(a); host_w_data = DW'(a);
      exp_mem[a] = DW'(a);
      if (a == 0) begin
        #1;
        n_chk++;
        if (mem_w_en !== 1'b1) $display("FAIL preload_wen got %b required 1", mem_w_en);
        else n_pass++;
      end
    end
    @(negedge clk);
    host_w_en = 1'b0;
    #1;
    n_chk++;
    if (mem[63] !== 16'd63) $display("FAIL preload_word63 got %0d required 63", mem[63]);
    else n_pass++;
  endtask

  task automatic do_start(input logic [4:0] k);
    @(negedge clk);
    start = 1'b1; k_len = k;
    @(negedge clk);
    start = 1'b0;
    k_len = 5'd3;
  endtask

  // Checks one feed from the first FEED cycle (c=0) through the following IDLE cycle.
  task automatic check_feed(input int k, input int poke_c, input int wr_c, input bit restart);
    logic [AW-1:0] ea [4];
    logic [3:0]    elv;
    lv0_cnt = 0;
    for (int c = 0; c <= k + 5; c++) begin
      if (c > 0) @(negedge clk);
      start       = (c == poke_c) || (restart && c >= k + 4);
      if (restart && c == k + 4) k_len = 5'(k);
      host_w_en   = (c == wr_c);
      host_w_addr = 6'd20;
      host_w_data = 16'd99;
      #1;
      for (int i = 0; i < 4; i++) begin
        ea[i]  = (c <= k + 2 && c >= i && c < i + k) ? AW'(i * 16 + c - i) : '0;
        elv[i] = (c >= 1 && c - 1 <= k + 2 && c - 1 >= i && c - 1 < i + k);
      end
      n_chk++;
      if ({read_addr_0, read_addr_1, read_addr_2, read_addr_3} !== {ea[0], ea[1], ea[2], ea[3]})
        $display("FAIL feed_addr k=%0d c=%0d got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", k, c,
                 read_addr_0, read_addr_1, read_addr_2, read_addr_3, ea[0], ea[1], ea[2], ea[3]);
      else n_pass++;
      n_chk++;
      if (lane_valid !== elv) $display("FAIL feed_lv k=%0d c=%0d got %b required %b", k, c, lane_valid, elv);
      else n_pass++;
      n_chk++;
      if ({busy, done} !== {c <= k + 4, c == k + 4})
        $display("FAIL feed_busy_done k=%0d c=%0d got %b%b required %b%b", k, c, busy, done, c <= k + 4, c == k + 4);
      else n_pass++;
      n_chk++;
      if (wr_reject !== (c == wr_c + 1)) $display("FAIL feed_wr_reject k=%0d c=%0d got %b required %b", k, c, wr_reject, c == wr_c + 1);
      else n_pass++;
      if (c == wr_c) begin
        n_chk++;
        if (mem_w_en !== 1'b0) $display("FAIL feed_wen_gated c=%0d got %b required 0", c, mem_w_en);
        else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
        if (elv[i]) begin
          n_chk++;
          if (rd[i] !== exp_mem[i * 16 + c - 1 - i])
            $display("FAIL feed_data k=%0d c=%0d lane=%0d got %0d required %0d", k, c, i, rd[i], exp_mem[i * 16 + c - 1 - i]);
          else n_pass++;
        end
      end
      if (lane_valid[0] === 1'b1) lv0_cnt++;
    end
    host_w_en = 1'b0;
  endtask

  task automatic test_feed_k4();
    logic [23:0] ea  [10];
    logic [3:0]  elv [10];
    ea  = '{{6'd0, 6'd0,  6'd0,  6'd0},  {6'd1, 6'd16, 6'd0,  6'd0},
            {6'd2, 6'd17, 6'd32, 6'd0},  {6'd3, 6'd18, 6'd33, 6'd48},
            {6'd0, 6'd19, 6'd34, 6'd49}, {6'd0, 6'd0,  6'd35, 6'd50},
            {6'd0, 6'd0,  6'd0,  6'd51}, 24'd0, 24'd0, 24'd0};
    elv = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
            4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    do_start(5'd4);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_chk++;
      if ({read_addr_0, read_addr_1, read_addr_2, read_addr_3} !== ea[c] ||
          lane_valid !== elv[c] || busy !== (c < 9) || done !== (c == 8))
        $display("FAIL k4_table c=%0d got addr=%0d/%0d/%0d/%0d lv=%b busy=%b done=%b required addr=%h lv=%b busy=%b done=%b",
                 c, read_addr_0, read_addr_1, read_addr_2, read_addr_3, lane_valid, busy, done,
                 ea[c], elv[c], c < 9, c == 8);
      else n_pass++;
    end
  endtask

  task automatic test_clamp_zero();
    do_start(5'd0);
    #1;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL k0_ignored got busy=%b required 0", busy);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({busy, lane_valid} !== 5'b0) $display("FAIL k0_idle got busy=%b lv=%b required 0", busy, lane_valid);
    else n_pass++;
    do_start(5'd20);
    check_feed(16, -1, -10, 1'b0);
    n_chk++;
    if (lv0_cnt != 16) $display("FAIL k20_lv0_count got %0d required 16", lv0_cnt);
    else n_pass++;
  endtask

  task automatic test_write_gating();
    @(negedge clk);
    host_w_en = 1'b1; host_w_addr = 6'd20; host_w_data = 16'd42;
    start = 1'b1; k_len = 5'd8;
    exp_mem[20] = 16'd42;
    #1;
    n_chk++;
    if ({mem_w_en, mem_w_addr, mem_w_data} !== {1'b1, 6'd20, 16'd42})
      $display("FAIL idle_write got en=%b addr=%0d data=%0d required 1/20/42", mem_w_en, mem_w_addr, mem_w_data);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; host_w_en = 1'b0;
    check_feed(8, -1, 1, 1'b0);
    n_chk++;
    if (mem[20] !== 16'd42) $display("FAIL word20_kept got %0d required 42", mem[20]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_start(5'd4);
    check_feed(4, 2, -10, 1'b1);
    @(negedge clk);
    start = 1'b0;
    check_feed(4, -1, -10, 1'b0);
  endtask

  task automatic test_reset_mid_feed();
    do_start(5'd8);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, lane_valid, wr_reject, mem_w_en} !== 8'b0 ||
        {read_addr_0, read_addr_1, read_addr_2, read_addr_3} !== 24'b0)
      $display("FAIL mid_reset got busy=%b done=%b lv=%b rej=%b wen=%b addr=%0d/%0d/%0d/%0d required all 0",
               busy, done, lane_valid, wr_reject, mem_w_en, read_addr_0, read_addr_1, read_addr_2, read_addr_3);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done} !== 2'b00) $display("FAIL mid_reset_no_done got busy=%b done=%b required 00", busy, done);
    else n_pass++;
    do_start(5'd8);
    check_feed(8, -1, -10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_feed_k4();
    test_clamp_zero();
    test_write_gating();
    test_back_to_back();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
